// File: rtl/led_counter_pkg.sv
// Shared types and helpers for the LED counter: mode encoding, Gray
// conversion and the prescaler divide ratio.
package led_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_GRAY   = 2'd3
  } mode_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Clock cycles per counter step; callers keep the result >= 2.
  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: two-flop synchroniser followed by a stability
// counter; reports the debounced pressed level and a one-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level_n_q;
  logic [CW-1:0] stab_cnt;
  logic          press_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      level_n_q <= 1'b1;
      stab_cnt  <= '0;
      press_q   <= 1'b0;
    end else begin
      sync_p0 <= key_n;
      // synchronised sample available from here on
      sync_p1 <= sync_p0;
      press_q <= 1'b0;
      if (sync_p1 == level_n_q) begin
        stab_cnt <= '0;
      end else if (stab_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // Nth consecutive differing sample: accept the new level
        level_n_q <= sync_p1;
        stab_cnt  <= '0;
        press_q   <= ~sync_p1;
      end else begin
        stab_cnt <= stab_cnt + CW'(1);
      end
    end
  end

  assign pressed = ~level_n_q;
  assign press   = press_q;

endmodule

// File: rtl/led_counter_modes.sv
// LED clock-counter: prescaled tick steps a counter in up/down/bounce/Gray
// mode; a debounced pushbutton cycles the mode.
module led_counter_modes
  import led_counter_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 50000000,
  parameter int TICK_HZ         = 10,
  parameter int CNT_WIDTH       = 7,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 EXTCLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 MODE_BTN,
  input  logic                 LOAD,
  input  logic [CNT_WIDTH-1:0] LOAD_VAL,
  output logic [CNT_WIDTH:0]   LEDG,
  output logic [1:0]           MODE,
  output logic                 TICK
);

  localparam int TICK_DIV = tick_div(CLK_FREQ_HZ, TICK_HZ);
  localparam int PW       = $clog2(TICK_DIV);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [PW-1:0]        presc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_step;
  logic [CNT_WIDTH-1:0] disp;
  mode_t                mode_q;
  logic                 dir_up_q;
  logic                 dir_step;
  logic                 tick_q;
  logic                 term;
  logic                 btn_level;
  logic                 btn_press;
  logic                 mode_adv;
  logic                 presc_wrap;
  logic                 step;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode_key (
    .clk    (EXTCLK),
    .rst    (RST),
    .key_n  (MODE_BTN),
    .pressed(btn_level),
    .press  (btn_press)
  );

  assign mode_adv   = btn_press & btn_level;
  assign presc_wrap = (presc_q == PW'(TICK_DIV - 1));
  // LOAD owns the counter for its cycle, so it swallows a coinciding tick
  assign step       = EN & presc_wrap & ~LOAD;

  always_comb begin
    cnt_step = cnt_q;
    dir_step = dir_up_q;
    case (mode_q)
      MODE_UP, MODE_GRAY: cnt_step = cnt_q + CNT_WIDTH'(1);
      MODE_DOWN:          cnt_step = cnt_q - CNT_WIDTH'(1);
      MODE_BOUNCE: begin
        if (dir_up_q) begin
          if (cnt_q == CNT_MAX) begin
            cnt_step = cnt_q - CNT_WIDTH'(1);
            dir_step = 1'b0;
          end else begin
            cnt_step = cnt_q + CNT_WIDTH'(1);
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_step = CNT_WIDTH'(1);
            dir_step = 1'b1;
          end else begin
            cnt_step = cnt_q - CNT_WIDTH'(1);
          end
        end
      end
      default: cnt_step = cnt_q;
    endcase
  end

  always_ff @(posedge EXTCLK) begin
    if (RST) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_UP;
      dir_up_q <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      tick_q <= step;
      if (LOAD) begin
        cnt_q   <= LOAD_VAL;
        presc_q <= '0;
      end else if (EN) begin
        presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
        if (step) cnt_q <= cnt_step;
      end
      // a mode change restarts bounce upward; the step above used the old mode
      if (mode_adv) begin
        dir_up_q <= 1'b1;
        mode_q   <= mode_t'(mode_q + 2'd1);
      end else if (step) begin
        dir_up_q <= dir_step;
      end
    end
  end

  always_comb begin
    term = 1'b0;
    disp = cnt_q;
    case (mode_q)
      MODE_UP:     term = (cnt_q == CNT_MAX);
      MODE_DOWN:   term = (cnt_q == '0);
      MODE_BOUNCE: term = (cnt_q == CNT_MAX) || (cnt_q == '0);
      MODE_GRAY: begin
        term = (cnt_q == CNT_MAX);
        disp = CNT_WIDTH'(bin2gray(32'(cnt_q)));
      end
      default: term = 1'b0;
    endcase
  end

  assign LEDG = {term, disp};
  assign MODE = mode_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_led_counter_modes.sv
// Directed bench for led_counter_modes with TICK_DIV=10, 3-bit counter and
// a 4-cycle debounce window.
module tb_led_counter_modes;

  logic       EXTCLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b1;
  logic       MODE_BTN = 1'b1;
  logic       LOAD = 1'b1;
  logic [2:0] LOAD_VAL = 3'd5;
  logic [3:0] LEDG;
  logic [1:0] MODE;
  logic       TICK;

  int total = 0;
  int bad = 0;

  led_counter_modes #(
    .CLK_FREQ_HZ    (100),
    .TICK_HZ        (10),
    .CNT_WIDTH      (3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .EXTCLK  (EXTCLK),
    .RST     (RST),
    .EN      (EN),
    .MODE_BTN(MODE_BTN),
    .LOAD    (LOAD),
    .LOAD_VAL(LOAD_VAL),
    .LEDG    (LEDG),
    .MODE    (MODE),
    .TICK    (TICK)
  );

  always #5 EXTCLK = ~EXTCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge EXTCLK);
    #1;
  endtask

  task automatic press_btn();
    MODE_BTN = 1'b0;
    step(8);
    MODE_BTN = 1'b1;
    step(10);
  endtask

  initial begin
    // reset with EN and LOAD held high
    step(3);
    chk("rst_ledg", LEDG, 4'b0000);
    chk("rst_mode", MODE, 2'd0);
    chk("rst_tick", TICK, 1'b0);
    RST = 1'b0;
    LOAD = 1'b0;

    step(9);
    chk("pre_tick", TICK, 1'b0);
    chk("pre_ledg", LEDG, 4'b0000);
    step(1);
    chk("tick10", TICK, 1'b1);
    chk("first_ledg", LEDG, 4'b0001);
    step(1);
    chk("tick_pulse", TICK, 1'b0);

    // UP to max then wrap
    step(59);
    chk("up_max", LEDG, 4'b1111);
    step(10);
    chk("up_wrap", LEDG, 4'b0000);

    // EN hold at prescaler 5
    step(5);
    EN = 1'b0;
    step(50);
    chk("hold_ledg", LEDG, 4'b0000);
    chk("hold_tick", TICK, 1'b0);
    EN = 1'b1;
    step(4);
    chk("resume_early", TICK, 1'b0);
    step(1);
    chk("resume_tick", TICK, 1'b1);
    chk("resume_ledg", LEDG, 4'b0001);

    // LOAD 0, then button glitch and real press with counting frozen
    EN = 1'b0;
    LOAD_VAL = 3'd0;
    LOAD = 1'b1;
    step(1);
    LOAD = 1'b0;
    chk("load0", LEDG, 4'b0000);
    MODE_BTN = 1'b0;
    step(2);
    MODE_BTN = 1'b1;
    step(8);
    chk("glitch_mode", MODE, 2'd0);
    MODE_BTN = 1'b0;
    step(6);
    chk("press_early", MODE, 2'd0);
    step(1);
    chk("press_down", MODE, 2'd1);
    step(1);
    MODE_BTN = 1'b1;
    step(10);
    chk("release_mode", MODE, 2'd1);
    chk("down_flag0", LEDG, 4'b1000);
    EN = 1'b1;
    step(10);
    chk("down_wrap", LEDG, 4'b0111);

    // BOUNCE from 6
    EN = 1'b0;
    press_btn();
    chk("mode_bounce", MODE, 2'd2);
    LOAD_VAL = 3'd6;
    LOAD = 1'b1;
    step(1);
    LOAD = 1'b0;
    chk("bnc_load", LEDG, 4'b0110);
    EN = 1'b1;
    step(10);
    chk("bnc_7", LEDG, 4'b1111);
    step(10);
    chk("bnc_6", LEDG, 4'b0110);
    step(10);
    chk("bnc_5", LEDG, 4'b0101);
    step(9);
    LOAD = 1'b1;
    step(1);
    LOAD = 1'b0;
    chk("load_tick_ledg", LEDG, 4'b0110);
    chk("load_tick_tick", TICK, 1'b0);

    // GRAY display
    EN = 1'b0;
    press_btn();
    chk("mode_gray", MODE, 2'd3);
    LOAD_VAL = 3'd2;
    LOAD = 1'b1;
    step(1);
    LOAD = 1'b0;
    chk("gray_2", LEDG, 4'b0011);
    EN = 1'b1;
    step(10);
    chk("gray_3", LEDG, 4'b0010);

    // reset mid-count
    step(4);
    RST = 1'b1;
    step(1);
    chk("rst2_ledg", LEDG, 4'b0000);
    chk("rst2_mode", MODE, 2'd0);
    chk("rst2_tick", TICK, 1'b0);
    RST = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
